// File: rtl/count_ctrl.sv
// Sequencing controller for the LED counter: arbitrates button commands against
// an auto-run prescaler and updates one registered count with wrap/saturate.
module count_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  input  logic             clr_pulse,
  input  logic             load_pulse,
  input  logic [WIDTH-1:0] load_value,
  input  logic             run_toggle,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             halted,
  output logic             wrap_pulse
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       r_state;
  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_running;
  logic             r_halted;

  logic             w_tick;
  logic             w_sat_tick;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [1:0]       w_state_nxt;
  logic [PW-1:0]    w_pre_nxt;

  // Count arbitration: clr > load > manual inc/dec > auto tick.
  always_comb begin
    w_tick     = (r_state == S_RUN) && (r_pre == PRE_LAST);
    w_cnt_nxt  = r_count;
    w_wrap_nxt = 1'b0;
    w_sat_tick = 1'b0;
    if (clr_pulse) begin
      w_cnt_nxt = '0;
    end else if (load_pulse) begin
      w_cnt_nxt = load_value;
    end else if (inc_pulse ^ dec_pulse) begin
      if (inc_pulse) begin
        if (r_count != CNT_MAX) w_cnt_nxt = r_count + WIDTH'(1);
        else if (wrap_en) begin
          w_cnt_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end
      end else begin
        if (r_count != '0) w_cnt_nxt = r_count - WIDTH'(1);
        else if (wrap_en) begin
          w_cnt_nxt  = CNT_MAX;
          w_wrap_nxt = 1'b1;
        end
      end
    end else if (!inc_pulse && !dec_pulse && w_tick) begin
      if (r_count != CNT_MAX) w_cnt_nxt = r_count + WIDTH'(1);
      else if (wrap_en) begin
        w_cnt_nxt  = '0;
        w_wrap_nxt = 1'b1;
      end else begin
        w_sat_tick = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (run_toggle) w_state_nxt = S_RUN;
      S_RUN:   if (run_toggle) w_state_nxt = S_IDLE;
               else if (w_sat_tick) w_state_nxt = S_HALT;
      S_HALT:  if (run_toggle || clr_pulse) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Prescaler only advances while staying in RUN; entry, exit, clr/load and tick restart it.
  always_comb begin
    if (r_state != S_RUN || w_state_nxt != S_RUN || clr_pulse || load_pulse || w_tick)
      w_pre_nxt = '0;
    else
      w_pre_nxt = r_pre + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pre     <= '0;
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_count   <= w_cnt_nxt;
      r_wrap    <= w_wrap_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_halted  <= (w_state_nxt == S_HALT);
    end
  end

  assign count      = r_count;
  assign running    = r_running;
  assign halted     = r_halted;
  assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: a stimulus process pushes model predictions,
// a monitor pops one prediction per cycle and compares it with the DUT outputs.
module tb_count_ctrl;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    int count;
    bit running;
    bit halted;
    bit wrap;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, inc_pulse, dec_pulse, clr_pulse, load_pulse, run_toggle, wrap_en;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         running, halted, wrap_pulse;

  count_ctrl #(.WIDTH(W), .TICK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .clr_pulse(clr_pulse), .load_pulse(load_pulse), .load_value(load_value),
    .run_toggle(run_toggle), .wrap_en(wrap_en), .count(count),
    .running(running), .halted(halted), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 0;

  // Behavioural model: mode flags plus cycles elapsed since the auto-run phase restarted.
  int m_cnt = 0;
  bit m_run = 0, m_halt = 0;
  int m_phase = 0;

  task automatic step(input bit rst, input bit inc, input bit dec, input bit clr,
                      input bit ld, input int lv, input bit rt, input bit wr);
    exp_t e;
    bit   tick, sat_tick, wrapped;
    int   c;
    @(negedge clk);
    reset = rst; inc_pulse = inc; dec_pulse = dec; clr_pulse = clr;
    load_pulse = ld; load_value = W'(lv); run_toggle = rt; wrap_en = wr;
    wrapped = 0; sat_tick = 0;
    if (rst) begin
      m_cnt = 0; m_run = 0; m_halt = 0; m_phase = 0;
    end else begin
      tick = m_run && (m_phase == DIV - 1);
      c = m_cnt;
      if (clr) c = 0;
      else if (ld) c = lv & MAXV;
      else if (inc && dec) c = m_cnt;
      else if (inc || (!dec && tick)) begin
        if (m_cnt < MAXV) c = m_cnt + 1;
        else if (wr) begin c = 0; wrapped = 1; end
        else sat_tick = !inc;
      end else if (dec) begin
        if (m_cnt > 0) c = m_cnt - 1;
        else if (wr) begin c = MAXV; wrapped = 1; end
      end
      m_cnt = c;
      if (m_run) m_phase = (clr || ld || tick) ? 0 : m_phase + 1;
      if (m_run) begin
        if (rt) m_run = 0;
        else if (sat_tick) begin m_run = 0; m_halt = 1; end
      end else if (m_halt) begin
        if (rt || clr) m_halt = 0;
      end else if (rt) begin
        m_run = 1;
      end
      if (!m_run) m_phase = 0;
    end
    e.count = m_cnt; e.running = m_run; e.halted = m_halt; e.wrap = wrapped;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit wr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, wr);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a new registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", int'(count), e.count);
        chk("running", int'(running), int'(e.running));
        chk("halted", int'(halted), int'(e.halted));
        chk("wrap_pulse", int'(wrap_pulse), int'(e.wrap));
      end else if (stim_done) begin
        break;
      end
    end
  end

  initial begin
    bit wr;
    int lv;
    reset = 1; inc_pulse = 0; dec_pulse = 0; clr_pulse = 0; load_pulse = 0;
    load_value = '0; run_toggle = 0; wrap_en = 1;

    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    // three increments from reset
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 1);
    idle(1, 1);
    // wrap and saturate at max
    step(0, 0, 0, 0, 1, 8'hFF, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    idle(1, 1);
    step(0, 0, 0, 0, 1, 8'hFF, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    // decrement at zero, both modes
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 1);
    idle(1, 1);
    // priority: clr over load over inc, then inc+dec cancels
    step(0, 1, 0, 1, 1, 8'h55, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0, 1);
    idle(1, 1);
    // auto-run three steps, then stop
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(12, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(6, 1);
    // run into saturation -> HALT, then clr
    step(0, 0, 0, 0, 1, 8'hFE, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(10, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    idle(2, 0);
    // reset mid-RUN with a coincident inc
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 8'h23, 0, 1);
    idle(2, 1);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    idle(10, 1);

    // randomized traffic, pulses sparse enough for auto ticks to land
    wr = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) wr = ~wr;
      case ($urandom_range(3))
        0: lv = 0;
        1: lv = MAXV;
        2: lv = MAXV - 1;
        default: lv = int'($urandom_range(MAXV));
      endcase
      step($urandom_range(199) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
           $urandom_range(39) == 0, $urandom_range(29) == 0, lv,
           $urandom_range(24) == 0, wr);
    end
    idle(2, wr);
    stim_done = 1;
    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Sequencing controller for the 8-bit LED counter datapath. It takes one-cycle command pulses from the synchronised, debounced and edge-detected buttons (increment, decrement, clear, load, run/stop) and arbitrates them against an internal auto-run prescaler. It then updates a single registered count with programmable wrap or saturate behaviour. It sits between the edge detectors and the LED output, replacing a free-standing increment-only counter.

## Interface
- `WIDTH`, default 8: count width in bits.
- `TICK_DIV`, default 50_000_000: clock cycles per auto-run step. Must be at least 2.
- `clk`, input, 1: system clock, 100 MHz. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset. It dominates every other input.
- `inc_pulse`, input, 1: one-cycle manual increment request.
- `dec_pulse`, input, 1: one-cycle manual decrement request.
- `clr_pulse`, input, 1: one-cycle clear request (count becomes 0).
- `load_pulse`, input, 1: one-cycle load request (count becomes `load_value`).
- `load_value`, input, WIDTH: value captured on `load_pulse`.
- `run_toggle`, input, 1: one-cycle request to start or stop auto-run.
- `wrap_en`, input, 1: 1 selects wrap-around, 0 selects saturate. Level input, sampled each cycle.
- `count`, output, WIDTH: registered count value.
- `running`, output, 1: high while the state is RUN.
- `halted`, output, 1: high while the state is HALT.
- `wrap_pulse`, output, 1: one-cycle strobe on any wrap, either max to 0 or 0 to max.

## Operation
- States:
  - IDLE: manual control only.
  - RUN: auto-increment every TICK_DIV cycles.
  - HALT: auto-run hit the maximum count with saturation selected.
- Transitions:
  - IDLE to RUN on `run_toggle`.
  - RUN to IDLE on `run_toggle`.
  - RUN to HALT when an auto step is applied with count = 2^WIDTH-1 and `wrap_en` = 0.
  - HALT to IDLE on `run_toggle` or `clr_pulse`.
  - `run_toggle` in the same cycle as other commands: the state change and the count operation both take effect.
- Per-cycle arbitration, fixed priority: clr, then load, then manual inc/dec, then auto tick. Only the highest-priority count operation is applied; lower ones are dropped and not queued.
- `inc_pulse` and `dec_pulse` in the same cycle cancel out: no count change and no wrap_pulse. A lower-priority auto tick is still dropped in that cycle.
- Increment:
  - Below max: count + 1.
  - At max with `wrap_en` = 1: count becomes 0 and `wrap_pulse` fires.
  - At max with `wrap_en` = 0: count holds.
- Decrement:
  - Above 0: count - 1.
  - At 0 with `wrap_en` = 1: count becomes max and `wrap_pulse` fires.
  - At 0 with `wrap_en` = 0: count holds.
- Auto tick: internal prescaler counts 0 to TICK_DIV-1 in RUN only. A tick is issued when prescaler = TICK_DIV-1, and the prescaler then returns to 0. The tick is an increment request.
- Prescaler is cleared in these cases:
  - in IDLE and HALT;
  - on IDLE to RUN entry;
  - on any clr or load applied while in RUN.
- A manual inc/dec in RUN does not disturb the prescaler. An auto tick coinciding with a manual op is dropped.
- Manual ops are accepted in all states. In HALT, inc saturates and dec decrements, but the state stays HALT.

## Timing
- Reset values: count = 0, state IDLE, prescaler 0, running = 0, halted = 0, wrap_pulse = 0.
- Reset mid-RUN or mid-HALT returns to IDLE with count 0 at the next edge. Inputs in that cycle are ignored.
- Command latency: 1 cycle. A pulse sampled at edge N is reflected in `count` after edge N.
- `wrap_pulse` is registered. It is high for exactly the one cycle following the edge that performed the wrap, aligned with the new count.
- `running` and `halted` are registered state decodes, valid the cycle after the transition edge.
- Auto-run: with `run_toggle` sampled at edge N, the first step appears in `count` after edge N+TICK_DIV. Later steps follow every TICK_DIV cycles.
- HALT entry happens on the same edge as the saturated (non-changing) auto step: `halted` goes high and `running` goes low.
- Held inputs: each cycle a pulse input is high counts as a separate request. Upstream edge detection guarantees single-cycle pulses.

## Test plan
- Reset, then 3 inc_pulse: count goes 0, 1, 2, 3; each update is 1 cycle after its pulse; wrap_pulse stays 0.
- load_pulse with load_value = 8'hFF, then inc with wrap_en = 1: count = 8'h00 and wrap_pulse high for 1 cycle. Repeat with wrap_en = 0: count stays 8'hFF and wrap_pulse stays 0.
- Same-cycle clr_pulse + load_pulse(8'h55) + inc_pulse: count = 0. Then inc and dec together: count unchanged.
- TICK_DIV = 4, run_toggle at edge N: count increments after edges N+4, N+8, N+12. run_toggle again: count freezes and running = 0.
- TICK_DIV = 4, load 8'hFE, RUN, wrap_en = 0: count reaches 8'hFF, then the next tick asserts halted = 1 with count held at 8'hFF. clr_pulse then gives IDLE with count = 0.
- Reset asserted mid-RUN with count = 8'h23 and a manual inc in the same cycle: next cycle count = 0, running = 0, and no auto step occurs afterwards.
